// File: rtl/snake_ram.sv
// Single-port RAM with a shared tri-state data bus and a one-cycle registered read.
// Define SNAKE_RAM_CLEAR_EN to zero the whole array, one word per cycle, after every reset.
module snake_ram #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wr_en_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] addr_i,
    inout  wire  [DATA_W-1:0] data_io,
    output logic              rd_valid_o,
    output logic              busy_o
);

    localparam int DEPTH = 1 << ADDR_W;

`ifdef SNAKE_RAM_CLEAR_EN
    typedef enum logic [1:0] {CLEAR, IDLE, WRITE, READ} state_t;
    localparam state_t RESET_STATE = CLEAR;
`else
    typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;
    localparam state_t RESET_STATE = IDLE;
`endif

    state_t            state;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rd_data_q;
    logic              drv_en_q;
    logic              in_clear;
    logic              wr_fire;
    logic              rd_fire;

`ifdef SNAKE_RAM_CLEAR_EN
    logic [ADDR_W-1:0] clr_cnt;
    assign in_clear = (state == CLEAR);
`else
    assign in_clear = 1'b0;
`endif

    // Write outranks read whenever both requests are raised together.
    assign wr_fire = !rst_i && !in_clear && wr_en_i;
    assign rd_fire = !rst_i && !in_clear && rd_en_i && !wr_en_i;

    // NOTE: the storage array has no reset; clearing it is the optional sweep's job,
    // so a plain reset leaves the contents intact.
    always_ff @(posedge clk_i) begin
`ifdef SNAKE_RAM_CLEAR_EN
        if (!rst_i && in_clear) begin
            mem[clr_cnt] <= '0;
        end else
`endif
        if (wr_fire) begin
            mem[addr_i] <= data_io;
        end
    end

    // NOTE: all state is updated with non-blocking assignments so every register
    // samples the pre-edge value of the array; this is what gives read-before-write.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_data_q <= '0;
            drv_en_q  <= 1'b0;
        end else if (rd_fire) begin
            rd_data_q <= mem[addr_i];
            drv_en_q  <= 1'b1;
        end else if (!rd_en_i || wr_en_i) begin
            drv_en_q  <= 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= RESET_STATE;
`ifdef SNAKE_RAM_CLEAR_EN
            clr_cnt <= '0;
`endif
        end else begin
            case (state)
`ifdef SNAKE_RAM_CLEAR_EN
                CLEAR: begin
                    clr_cnt <= clr_cnt + ADDR_W'(1);
                    if (clr_cnt == '1) begin
                        state <= IDLE;
                    end
                end
`endif
                IDLE: begin
                    if (wr_en_i) begin
                        state <= WRITE;
                    end else if (rd_en_i) begin
                        state <= READ;
                    end
                end
                WRITE: begin
                    if (!wr_en_i) begin
                        state <= rd_en_i ? READ : IDLE;
                    end
                end
                READ: begin
                    if (wr_en_i) begin
                        state <= WRITE;
                    end else if (!rd_en_i) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The write request gates the driver directly so the bus is released in the same cycle.
    assign rd_valid_o = drv_en_q && !wr_en_i;
    assign data_io    = rd_valid_o ? rd_data_q : {DATA_W{1'bz}};
    assign busy_o     = rst_i || in_clear;

endmodule

// File: doc/snake_ram.md
SNAKE_RAM -- requirements
Module: snake_ram

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, meaning the address width; depth = 2^ADDR_W words.
REQ-002 The block SHALL have parameter DATA_W, default 4, meaning the word width.
REQ-003 The block SHALL have port clk_i, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_i, input, 1 bit, a synchronous active-high reset.
REQ-005 The block SHALL have port wr_en_i, input, 1 bit, the write request, level-sensitive.
REQ-006 The block SHALL have port rd_en_i, input, 1 bit, the read request, level-sensitive.
REQ-007 The block SHALL have port addr_i, input, ADDR_W bits, the word address.
REQ-008 The block SHALL have port data_io, inout, DATA_W bits, the shared data bus: driven by the initiator during writes and by this block during reads.
REQ-009 The block SHALL have port rd_valid_o, output, 1 bit, high while this block drives data_io.
REQ-010 The block SHALL have port busy_o, output, 1 bit, high while requests are ignored (reset or clear sweep).

Function
REQ-011 The block SHALL hold a DATA_W x 2^ADDR_W storage array, single port.
REQ-012 The FSM SHALL have states CLEAR, IDLE, WRITE and READ.
REQ-013 IDLE->WRITE when wr_en_i=1; IDLE->READ when rd_en_i=1 and wr_en_i=0; otherwise stay in IDLE.
REQ-014 WRITE->IDLE when wr_en_i=0 and rd_en_i=0; WRITE->READ when wr_en_i=0 and rd_en_i=1.
REQ-015 READ->WRITE when wr_en_i=1; READ->IDLE when rd_en_i=0.
REQ-016 On every edge where wr_en_i=1 and the state is not CLEAR, mem[addr_i] SHALL take data_io; repeated writes are idempotent; address changes take effect on the next edge.
REQ-017 On every edge where rd_en_i=1, wr_en_i=0 and the state is not CLEAR, rd_data_q SHALL take mem[addr_i], giving one-cycle read latency and tracking addr_i changes with one-cycle delay.
REQ-018 A read of an address written on the same edge SHALL return the old contents (read-before-write); it can only happen across separate cycles because write has priority.
REQ-019 drv_en_q SHALL set on the edge of REQ-017 and clear on any edge with rd_en_i=0 or wr_en_i=1.
REQ-020 data_io SHALL be driven with rd_data_q only when drv_en_q=1 and wr_en_i=0 (combinational gate); otherwise it SHALL be high-impedance, so raising wr_en_i releases the bus in the same cycle.
REQ-021 rd_valid_o SHALL equal drv_en_q AND NOT wr_en_i.
REQ-022 If wr_en_i and rd_en_i are both high, the write SHALL win, no read SHALL occur and the bus SHALL stay undriven by this block.
REQ-023 Address arithmetic SHALL wrap modulo 2^ADDR_W; address 255 (default width) SHALL be fully usable.

Reset
REQ-024 On an edge with rst_i=1, the block SHALL set drv_en_q=0, rd_valid_o=0 and rd_data_q=0, and leave data_io high-impedance from the next edge.
REQ-025 The reset state SHALL be CLEAR if SNAKE_RAM_CLEAR_EN is defined, else IDLE.
REQ-026 busy_o SHALL be 1 while rst_i=1.
REQ-027 Reset asserted mid-write or mid-read SHALL abort the operation; no write SHALL occur on the reset edge.

Configuration
REQ-028 With macro SNAKE_RAM_CLEAR_EN defined, CLEAR SHALL write 0 to one address per cycle, counting from 0 up to 2^ADDR_W-1, with busy_o=1 and all requests ignored, then go to IDLE; busy_o SHALL fall in the cycle IDLE is entered (256 cycles after reset release at default width).
REQ-029 With SNAKE_RAM_CLEAR_EN undefined, CLEAR and its counter SHALL be absent, reset SHALL leave memory contents unchanged, and busy_o SHALL equal rst_i.

Verification
REQ-030 Reset, then with the clear macro on: read addresses 0 and 255 -> data_io=0; busy_o high for 256 cycles after reset release.
REQ-031 Write (3,1), (15,3), (63,7), (255,15), each with wr_en_i held for 6 cycles, then read each -> data_io=1,3,7,15 one cycle after rd_en_i, rd_valid_o=1, and Z after rd_en_i falls.
REQ-032 Hold rd_en_i with addr_i stepping 3->15 -> data_io changes 1->3 exactly one edge after the address change.
REQ-033 During a read of 63, raise wr_en_i with data 9 -> bus goes Z in the same cycle, mem[63]=9; a subsequent read returns 9.
REQ-034 Assert rst_i for one cycle mid-write of (100,5) -> no write on the reset edge; with the clear macro off, previously written addresses keep their values.
